// File: rtl/cpsr_update_pkg.sv
// Shared constants and types for the CPSR flag-generation stage: condition
// codes, flag bit positions, flag-source encodings and the FSM state type.
package cpsr_update_pkg;

  localparam int CPSR_W = 32;

  localparam int FLAG_N = 31;
  localparam int FLAG_Z = 30;
  localparam int FLAG_C = 29;
  localparam int FLAG_V = 28;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {
    SRC_ARITH = 2'd0,
    SRC_LOGIC = 2'd1,
    SRC_MSR   = 2'd2,
    SRC_RSVD  = 2'd3
  } flag_src_e;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Replace each byte lane whose mask bit is set; leave the others alone.
  function automatic logic [CPSR_W-1:0] msrMerge(
    input logic [CPSR_W-1:0] cur,
    input logic [CPSR_W-1:0] data,
    input logic [3:0]        mask
  );
    logic [CPSR_W-1:0] merged;
    merged = cur;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) merged[b*8 +: 8] = data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/cpsr_update_cond_check.sv
// Purely combinational ARM condition-code evaluator. Kept as its own module
// so the branch unit can reuse exactly the same pass/fail decision.
module cond_check
  import cpsr_update_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign {w_n, w_z, w_c, w_v} = nzcv;

  // Decode the condition field against the current NZCV flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = !w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = !w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = !w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = !w_v;
      COND_HI: pass = w_c && !w_z;
      COND_LS: pass = !w_c || w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = !w_z && (w_n == w_v);
      COND_LE: pass = w_z || (w_n != w_v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpsr_update.sv
// Flag-generation / condition-check stage in front of the CPSR register.
// A shadow copy of the CPSR is the authority for condition checks so that
// back-to-back flag dependencies see fresh flags despite the register's
// one-cycle read latency. After reset the shadow is reloaded from cpsr_q.
module cpsr_update
  import cpsr_update_pkg::*;
#(
  parameter int FULLW       = CPSR_W,
  parameter int SYNC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cond,
  input  logic             in_set_flags,
  input  logic [1:0]       in_flag_src,
  input  logic [FULLW-1:0] in_result,
  input  logic             in_alu_c,
  input  logic             in_alu_v,
  input  logic             in_shift_c,
  input  logic [FULLW-1:0] in_msr_data,
  input  logic [3:0]       in_msr_mask,
  input  logic [FULLW-1:0] cpsr_q,
  output logic             cpsr_we,
  output logic [FULLW-1:0] cpsr_d,
  output logic             out_valid,
  output logic             out_pass,
  output logic [3:0]       flags
);

  localparam int CNTW = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(SYNC_CYCLES - 1);

  state_e           r_state;
  state_e           w_stateNext;
  logic [CNTW-1:0]  r_syncCnt;
  logic [CNTW-1:0]  w_cntNext;
  logic             w_sample;
  logic [FULLW-1:0] r_cpsr;
  logic [FULLW-1:0] w_cpsrNext;
  logic             w_update;
  logic             w_accept;
  logic             w_pass;

  cond_check u_condCheck (
    .cond (in_cond),
    .nzcv (r_cpsr[FLAG_N:FLAG_V]),
    .pass (w_pass)
  );

  assign flags    = r_cpsr[FLAG_N:FLAG_V];
  assign w_accept = in_valid & in_ready;

  // State and resync counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SYNC;
      r_syncCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_syncCnt <= w_cntNext;
    end
  end

  // Resync sequencing: wait out the register's read latency, then sample q once.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_syncCnt;
    w_sample    = 1'b0;
    in_ready    = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (r_syncCnt == LAST_CNT) begin
          w_stateNext = ST_RUN;
          w_cntNext   = '0;
          w_sample    = 1'b1;
        end else begin
          w_cntNext = r_syncCnt + CNTW'(1);
        end
      end
      ST_RUN: begin
        in_ready = 1'b1;
      end
      default: begin
        w_stateNext = ST_SYNC;
        w_cntNext   = '0;
      end
    endcase
  end

  // Build the candidate CPSR value for an accepted, passing instruction.
  always_comb begin
    w_cpsrNext = r_cpsr;
    w_update   = 1'b0;
    if (w_accept && w_pass) begin
      case (in_flag_src)
        SRC_ARITH: begin
          if (in_set_flags) begin
            w_update           = 1'b1;
            w_cpsrNext[FLAG_N] = in_result[FULLW-1];
            w_cpsrNext[FLAG_Z] = (in_result == '0);
            w_cpsrNext[FLAG_C] = in_alu_c;
            w_cpsrNext[FLAG_V] = in_alu_v;
          end
        end
        SRC_LOGIC: begin
          if (in_set_flags) begin
            w_update           = 1'b1;
            w_cpsrNext[FLAG_N] = in_result[FULLW-1];
            w_cpsrNext[FLAG_Z] = (in_result == '0);
            w_cpsrNext[FLAG_C] = in_shift_c;
          end
        end
        SRC_MSR: begin
          w_update   = 1'b1;
          w_cpsrNext = msrMerge(r_cpsr, in_msr_data, in_msr_mask);
        end
        default: begin
          w_update = 1'b0;
        end
      endcase
    end
  end

  // Shadow CPSR and registered outputs toward the CPSR register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpsr    <= '0;
      cpsr_we   <= 1'b0;
      cpsr_d    <= '0;
      out_valid <= 1'b0;
      out_pass  <= 1'b0;
    end else begin
      out_valid <= w_accept;
      out_pass  <= w_accept & w_pass;
      cpsr_we   <= w_update;
      if (w_sample) begin
        r_cpsr <= cpsr_q;
      end else if (w_update) begin
        r_cpsr <= w_cpsrNext;
      end
      if (w_update) begin
        cpsr_d <= w_cpsrNext;
      end
    end
  end

endmodule

// File: tb/tb_cpsr_update.sv
// Randomised scoreboard bench for cpsr_update. The stimulus side predicts
// each response from an abstract CPSR model and queues it; a negedge monitor
// pops and compares whenever the DUT raises out_valid. A small model of the
// downstream CPSR register closes the loop through cpsr_q.
module tb_cpsr_update;

  typedef struct {
    logic        pass;
    logic        we;
    logic [31:0] d;
    logic [3:0]  nzcv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cond;
  logic        in_set_flags;
  logic [1:0]  in_flag_src;
  logic [31:0] in_result;
  logic        in_alu_c;
  logic        in_alu_v;
  logic        in_shift_c;
  logic [31:0] in_msr_data;
  logic [3:0]  in_msr_mask;
  logic [31:0] cpsr_q;
  logic        cpsr_we;
  logic [31:0] cpsr_d;
  logic        out_valid;
  logic        out_pass;
  logic [3:0]  flags;

  logic [31:0] regQ = 32'h6000_0010;
  logic [31:0] mCpsr;
  logic [31:0] mLastD;
  exp_t        sbQ[$];
  exp_t        monItem;
  int          checks = 0;
  int          errors = 0;

  cpsr_update #(.FULLW(32), .SYNC_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cond      (in_cond),
    .in_set_flags (in_set_flags),
    .in_flag_src  (in_flag_src),
    .in_result    (in_result),
    .in_alu_c     (in_alu_c),
    .in_alu_v     (in_alu_v),
    .in_shift_c   (in_shift_c),
    .in_msr_data  (in_msr_data),
    .in_msr_mask  (in_msr_mask),
    .cpsr_q       (cpsr_q),
    .cpsr_we      (cpsr_we),
    .cpsr_d       (cpsr_d),
    .out_valid    (out_valid),
    .out_pass     (out_pass),
    .flags        (flags)
  );

  always #5 clk = ~clk;

  // Downstream CPSR register: not reset, only loaded through we/d.
  always @(posedge clk) begin
    if (cpsr_we) regQ <= cpsr_d;
  end
  assign cpsr_q = regQ;

  // ARM condition table in its paired form: even codes test a predicate,
  // odd codes test its inverse, and code 15 never passes.
  function automatic logic refPass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one instruction for a single cycle and queue its predicted response.
  task automatic applyStimulus(input logic [3:0] c, input logic sf, input logic [1:0] src,
                               input logic [31:0] res, input logic ac, input logic av,
                               input logic sc, input logic [31:0] md, input logic [3:0] mm);
    logic        p;
    logic        we;
    logic [31:0] nxt;
    @(negedge clk);
    in_valid     = 1'b1;
    in_cond      = c;
    in_set_flags = sf;
    in_flag_src  = src;
    in_result    = res;
    in_alu_c     = ac;
    in_alu_v     = av;
    in_shift_c   = sc;
    in_msr_data  = md;
    in_msr_mask  = mm;
    p   = refPass(c, mCpsr[31:28]);
    we  = 1'b0;
    nxt = mCpsr;
    if (p) begin
      if (src == 2'd0 && sf) begin
        nxt[31:28] = {res[31], res == 32'd0, ac, av};
        we = 1'b1;
      end else if (src == 2'd1 && sf) begin
        nxt[31:29] = {res[31], res == 32'd0, sc};
        we = 1'b1;
      end else if (src == 2'd2) begin
        for (int b = 0; b < 4; b++) begin
          if (mm[b]) nxt[b*8 +: 8] = md[b*8 +: 8];
        end
        we = 1'b1;
      end
    end
    if (we) begin
      mCpsr  = nxt;
      mLastD = nxt;
    end
    sbQ.push_back('{p, we, mLastD, mCpsr[31:28]});
  endtask

  task automatic goIdle(input int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic randomInstr();
    logic [3:0]  c;
    logic [31:0] res;
    int          r;
    c = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) c = 4'hE;
    r = $urandom_range(0, 3);
    if (r == 0)      res = 32'd0;
    else if (r == 1) res = 32'h8000_0000 | $urandom();
    else             res = $urandom();
    applyStimulus(c, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), res,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom(), 4'($urandom_range(0, 15)));
  endtask

  // Monitor: compare every DUT response against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          monItem = sbQ.pop_front();
          checkOutput("out_pass", 32'(out_pass), 32'(monItem.pass));
          checkOutput("cpsr_we", 32'(cpsr_we), 32'(monItem.we));
          checkOutput("cpsr_d", cpsr_d, monItem.d);
          checkOutput("flags", 32'(flags), 32'(monItem.nzcv));
        end
      end else begin
        checkOutput("idle_cpsr_we", 32'(cpsr_we), 32'd0);
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_cond      = 4'h0;
    in_set_flags = 1'b0;
    in_flag_src  = 2'd0;
    in_result    = 32'd0;
    in_alu_c     = 1'b0;
    in_alu_v     = 1'b0;
    in_shift_c   = 1'b0;
    in_msr_data  = 32'd0;
    in_msr_mask  = 4'd0;
    mCpsr        = 32'h6000_0010;
    mLastD       = 32'd0;

    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_pass", 32'(out_pass), 32'd0);
    checkOutput("rst_cpsr_we", 32'(cpsr_we), 32'd0);
    checkOutput("rst_cpsr_d", cpsr_d, 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);

    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("sync_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("sync_in_ready_high", 32'(in_ready), 32'd1);
    checkOutput("resync_flags", 32'(flags), 32'h6);

    // Arithmetic flags and zero-bubble dependent conditions.
    applyStimulus(4'hE, 1'b1, 2'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'd0, 4'd0);
    applyStimulus(4'hE, 1'b1, 2'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0);
    applyStimulus(4'h0, 1'b0, 2'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);
    applyStimulus(4'h1, 1'b0, 2'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0);

    // Logic flags keep V.
    applyStimulus(4'hE, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, 1'b0, 32'h1000_0000, 4'b1000);
    applyStimulus(4'hE, 1'b1, 2'd1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0);

    // Every condition code against four flag patterns.
    foreach (sbQ[i]) ;
    for (int p = 0; p < 4; p++) begin
      logic [3:0] pats [4] = '{4'b0000, 4'b0110, 4'b1001, 4'b1111};
      applyStimulus(4'hE, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, 1'b0, {pats[p], 28'd0}, 4'b1000);
      for (int c = 0; c < 16; c++) begin
        applyStimulus(4'(c), 1'b1, 2'd3, 32'd0, 1'b1, 1'b1, 1'b1, 32'd0, 4'd0);
      end
    end

    // MSR byte-lane merge, then an MSR that fails its condition.
    applyStimulus(4'hE, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b1000);
    applyStimulus(4'hE, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, 1'b0, 32'hF000_00FF, 4'b1000);
    applyStimulus(4'hF, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b1111);
    applyStimulus(4'h1, 1'b0, 2'd2, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b1111);
    goIdle(2);
    checkOutput("reg_after_msr", regQ, 32'hF000_0010);

    // Randomised traffic, with occasional idle gaps.
    for (int n = 0; n < 400; n++) begin
      randomInstr();
      if ($urandom_range(0, 9) == 0) goIdle(1);
    end
    goIdle(3);
    checkOutput("reg_tracks_model", regQ, mCpsr);

    // Reset arrives after an accept is presented but before its edge.
    @(negedge clk);
    in_valid     = 1'b1;
    in_cond      = 4'hE;
    in_set_flags = 1'b1;
    in_flag_src  = 2'd1;
    in_result    = mCpsr[30] ? 32'd1 : 32'd0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_cpsr_we", 32'(cpsr_we), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    mLastD   = 32'd0;
    sbQ.delete();
    repeat (2) @(negedge clk);
    checkOutput("midrst_reg_untouched", regQ, mCpsr);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10 && in_ready !== 1'b1; k++) @(negedge clk);
    checkOutput("midrst_resync_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_resync_flags", 32'(flags), 32'(mCpsr[31:28]));

    for (int n = 0; n < 40; n++) randomInstr();
    goIdle(3);
    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    checkOutput("reg_final", regQ, mCpsr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
